// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use bubble sequencing,
// mul/div busy tracking and a saturating stall-cycle counter.
module hazard_fwd_unit #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_id,
  input  logic [AW-1:0] rt_id,
  input  logic          use_rs_id,
  input  logic          use_rt_id,
  input  logic [AW-1:0] rd_ex,
  input  logic [AW-1:0] rd_mem,
  input  logic [AW-1:0] rd_wb,
  input  logic          wen_ex,
  input  logic          wen_mem,
  input  logic          wen_wb,
  input  logic          load_ex,
  input  logic          md_start_ex,
  input  logic          md_use_id,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall,
  output logic          flush_ex,
  output logic          md_busy,
  output logic [15:0]   stall_cnt
);

  typedef enum logic {
    S_IDLE       = 1'b0,
    S_LOAD_STALL = 1'b1
  } state_t;

  localparam logic [1:0]  LCNT_INIT    = 2'(LOAD_LAT - 1);
  localparam logic [3:0]  MD_INIT      = 4'(MD_LAT);
  localparam bit          MULTI_BUBBLE = (LOAD_LAT > 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_lcnt;
  logic [1:0]  w_lcnt_nxt;
  logic [3:0]  r_md_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_lu;
  logic        w_load_stall;
  logic        w_md_stall;
  logic        w_stall;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  // EX beats MEM beats WB; register 0 and non-writing stages never forward.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [AW-1:0] d_ex,
    input logic          we_ex,
    input logic [AW-1:0] d_mem,
    input logic          we_mem,
    input logic [AW-1:0] d_wb,
    input logic          we_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_ex && (d_ex != '0) && (d_ex == src))
      sel = 2'b10;
    else if (we_mem && (d_mem != '0) && (d_mem == src))
      sel = 2'b01;
    else if (we_wb && (d_wb != '0) && (d_wb == src))
      sel = 2'b11;
    return sel;
  endfunction

  // Stage p0: combinational hazard detection from the current ID/EX/MEM/WB view
  assign w_fwd_a = fwd_sel(rs_id, rd_ex, wen_ex, rd_mem, wen_mem, rd_wb, wen_wb);
  assign w_fwd_b = fwd_sel(rt_id, rd_ex, wen_ex, rd_mem, wen_mem, rd_wb, wen_wb);

  assign w_lu = load_ex && wen_ex && (rd_ex != '0) &&
                ((use_rs_id && (rd_ex == rs_id)) || (use_rt_id && (rd_ex == rt_id)));

  // Load-use FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  // Load-use FSM: next state; lu is ignored while bubbles are still draining
  always_comb begin
    w_state_nxt = r_state;
    w_lcnt_nxt  = r_lcnt;
    case (r_state)
      S_IDLE: begin
        if (w_lu && MULTI_BUBBLE) begin
          w_state_nxt = S_LOAD_STALL;
          w_lcnt_nxt  = LCNT_INIT;
        end
      end
      S_LOAD_STALL: begin
        if (r_lcnt <= 2'd1) begin
          w_state_nxt = S_IDLE;
          w_lcnt_nxt  = 2'd0;
        end else begin
          w_lcnt_nxt  = r_lcnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_lcnt_nxt  = 2'd0;
      end
    endcase
  end

  // Load-use FSM: outputs
  always_comb begin
    w_load_stall = 1'b0;
    case (r_state)
      S_IDLE:       w_load_stall = w_lu;
      S_LOAD_STALL: w_load_stall = 1'b1;
      default:      w_load_stall = 1'b0;
    endcase
  end

  // Mul/div occupancy: a start while busy restarts the full latency
  always_ff @(posedge clk) begin
    if (rst)
      r_md_cnt <= 4'd0;
    else if (md_start_ex)
      r_md_cnt <= MD_INIT;
    else if (r_md_cnt != 4'd0)
      r_md_cnt <= r_md_cnt - 4'd1;
  end

  assign w_md_stall = md_use_id && (r_md_cnt != 4'd0);
  assign w_stall    = !rst && (w_load_stall || w_md_stall);

  // Stage p1: saturating stall-cycle statistics
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 16'd0;
    else if (w_stall && (r_stall_cnt != CNT_MAX))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign fwd_a     = rst ? 2'b00 : w_fwd_a;
  assign fwd_b     = rst ? 2'b00 : w_fwd_b;
  assign stall     = w_stall;
  assign flush_ex  = w_stall;
  assign md_busy   = (r_md_cnt != 4'd0);
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit; two instances share stimulus so that
// single-bubble and three-bubble load-use behaviour are checked side by side.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_id, rt_id, rd_ex, rd_mem, rd_wb;
  logic       use_rs_id, use_rt_id, wen_ex, wen_mem, wen_wb;
  logic       load_ex, md_start_ex, md_use_id;

  logic [1:0]  fwd_a1, fwd_b1, fwd_a3, fwd_b3;
  logic        stall1, flush1, busy1, stall3, flush3, busy3;
  logic [15:0] cnt1, cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.AW(5), .LOAD_LAT(1), .MD_LAT(4)) dut1 (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .wen_wb(wen_wb),
    .load_ex(load_ex), .md_start_ex(md_start_ex), .md_use_id(md_use_id),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall(stall1), .flush_ex(flush1),
    .md_busy(busy1), .stall_cnt(cnt1)
  );

  hazard_fwd_unit #(.AW(5), .LOAD_LAT(3), .MD_LAT(4)) dut3 (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .wen_wb(wen_wb),
    .load_ex(load_ex), .md_start_ex(md_start_ex), .md_use_id(md_use_id),
    .fwd_a(fwd_a3), .fwd_b(fwd_b3), .stall(stall3), .flush_ex(flush3),
    .md_busy(busy3), .stall_cnt(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    rs_id = 0; rt_id = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    use_rs_id = 0; use_rt_id = 0; wen_ex = 0; wen_mem = 0; wen_wb = 0;
    load_ex = 0; md_start_ex = 0; md_use_id = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick();

    // Reset: outputs quiet even with forwarding and load-use conditions present
    rs_id = 5; rd_ex = 5; wen_ex = 1; load_ex = 1; use_rs_id = 1;
    settle();
    chk("rst_fwd_a", 32'(fwd_a1), 32'h0);
    chk("rst_stall", 32'(stall3), 32'h0);
    chk("rst_flush", 32'(flush3), 32'h0);
    clear_inputs();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_cnt", 32'(cnt1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);

    // Forwarding priority
    rs_id = 5; rd_ex = 5; wen_ex = 1; rd_mem = 5; wen_mem = 1;
    settle();
    chk("fwd_a_ex", 32'(fwd_a1), 32'h2);
    chk("fwd_b_none", 32'(fwd_b1), 32'h0);
    wen_ex = 0;
    settle();
    chk("fwd_a_mem", 32'(fwd_a1), 32'h1);
    rd_ex = 0; rd_mem = 0; rd_wb = 5; wen_wb = 1;
    settle();
    chk("fwd_a_wb", 32'(fwd_a1), 32'h3);
    rs_id = 0; rd_wb = 0; wen_ex = 1; wen_mem = 1;
    settle();
    chk("fwd_a_r0", 32'(fwd_a1), 32'h0);
    rt_id = 7; rd_ex = 7; wen_ex = 0; rd_mem = 7;
    settle();
    chk("fwd_b_mem", 32'(fwd_b1), 32'h1);
    chk("fwd_stall", 32'(stall1), 32'h0);
    clear_inputs();
    tick();

    // Load-use: one bubble on dut1, three on dut3
    load_ex = 1; rd_ex = 8; wen_ex = 1; rt_id = 8; use_rt_id = 1;
    settle();
    chk("lu1_stall", 32'(stall1), 32'h1);
    chk("lu1_flush", 32'(flush1), 32'h1);
    chk("lu3_stall_c1", 32'(stall3), 32'h1);
    tick();
    clear_inputs();
    settle();
    chk("lu1_after", 32'(stall1), 32'h0);
    chk("lu1_cnt", 32'(cnt1), 32'h1);
    chk("lu3_stall_c2", 32'(stall3), 32'h1);
    chk("lu3_flush_c2", 32'(flush3), 32'h1);
    tick();
    settle();
    chk("lu3_stall_c3", 32'(stall3), 32'h1);
    tick();
    settle();
    chk("lu3_after", 32'(stall3), 32'h0);
    chk("lu3_cnt", 32'(cnt3), 32'h3);
    chk("lu1_cnt_hold", 32'(cnt1), 32'h1);

    // No hazard when the register is not actually read, or is register 0
    load_ex = 1; rd_ex = 8; wen_ex = 1; rt_id = 8; use_rt_id = 0;
    settle();
    chk("lu_nouse", 32'(stall1), 32'h0);
    rd_ex = 0; rs_id = 0; use_rs_id = 1;
    settle();
    chk("lu_r0", 32'(stall3), 32'h0);
    clear_inputs();
    tick();

    // Mul/div busy window and restart
    md_start_ex = 1;
    settle();
    chk("md_c0_busy", 32'(busy1), 32'h0);
    tick();
    md_start_ex = 0;
    settle();
    chk("md_c1_busy", 32'(busy1), 32'h1);
    tick();
    md_use_id = 1; md_start_ex = 1;
    settle();
    chk("md_c2_stall", 32'(stall1), 32'h1);
    chk("md_c2_flush", 32'(flush1), 32'h1);
    tick();
    clear_inputs();
    settle();
    chk("md_c3_cnt", 32'(cnt1), 32'h2);
    tick(); tick(); tick();
    settle();
    chk("md_c6_busy", 32'(busy1), 32'h1);
    tick();
    settle();
    chk("md_c7_busy", 32'(busy1), 32'h0);
    md_use_id = 1;
    settle();
    chk("md_idle_use", 32'(stall1), 32'h0);
    clear_inputs();
    tick();

    // Reset in the second cycle of a three-bubble stall
    load_ex = 1; rd_ex = 9; wen_ex = 1; rs_id = 9; use_rs_id = 1; md_start_ex = 1;
    settle();
    chk("rstmid_c1", 32'(stall3), 32'h1);
    tick();
    clear_inputs();
    settle();
    chk("rstmid_c2_stall", 32'(stall3), 32'h1);
    chk("rstmid_c2_busy", 32'(busy3), 32'h1);
    rst = 1'b1;
    settle();
    chk("rstmid_gate", 32'(stall3), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("rstmid_stall", 32'(stall3), 32'h0);
    chk("rstmid_busy", 32'(busy3), 32'h0);
    chk("rstmid_cnt", 32'(cnt3), 32'h0);

    // Saturation: hold a mul/div stall long enough to pin the counter
    md_start_ex = 1; md_use_id = 1;
    for (int i = 0; i < 65600; i++) tick();
    settle();
    chk("sat_stall", 32'(stall1), 32'h1);
    chk("sat_cnt", 32'(cnt1), 32'hFFFF);
    tick();
    settle();
    chk("sat_hold", 32'(cnt1), 32'hFFFF);
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL take parameters: AW, default 5, register-address width; LOAD_LAT, default 1 (legal 1..3), load-use bubble count; MD_LAT, default 4 (legal 1..15), mul/div busy cycles.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports rs_id, rt_id, inputs, AW, ID-stage source register addresses.
REQ-005 SHALL have ports use_rs_id, use_rt_id, inputs, 1, ID instruction actually reads rs/rt.
REQ-006 SHALL have ports rd_ex, rd_mem, rd_wb, inputs, AW, destination register per stage.
REQ-007 SHALL have ports wen_ex, wen_mem, wen_wb, inputs, 1, stage writes its rd.
REQ-008 SHALL have port load_ex, input, 1, EX instruction is a load.
REQ-009 SHALL have ports md_start_ex, md_use_id, inputs, 1: mul/div starts in EX; ID instruction reads HI/LO.
REQ-010 SHALL have ports fwd_a, fwd_b, outputs, 2, operand select: 00 regfile, 10 EX, 01 MEM, 11 WB.
REQ-011 SHALL have ports stall, flush_ex, md_busy, outputs, 1: hold PC and IF/ID; bubble into ID/EX; mul/div in progress.
REQ-012 SHALL have port stall_cnt, output, 16, saturating count of stalled cycles.

Function
REQ-013 fwd_a SHALL be combinational: 10 if wen_ex, rd_ex!=0, rd_ex==rs_id; else 01 if same test on MEM; else 11 if same test on WB; else 00. fwd_b identical using rt_id.
REQ-014 Priority SHALL be EX > MEM > WB; register 0 is never forwarded; a stage with wen=0 is never a forwarding source.
REQ-015 Load-use hit (lu) SHALL be load_ex & wen_ex & rd_ex!=0 & ((use_rs_id & rd_ex==rs_id) | (use_rt_id & rd_ex==rt_id)).
REQ-016 FSM states SHALL be IDLE and LOAD_STALL, with a 2-bit bubble counter lcnt.
REQ-017 IDLE: lu SHALL assert stall and flush_ex the same cycle (combinational); if LOAD_LAT>1, next state LOAD_STALL with lcnt=LOAD_LAT-1.
REQ-018 LOAD_STALL SHALL assert stall and flush_ex regardless of inputs, decrement lcnt each cycle, and return to IDLE in the cycle lcnt reaches 0 after its decrement; total bubbles per load-use = LOAD_LAT.
REQ-019 lu SHALL NOT be evaluated in LOAD_STALL; the FSM re-checks lu only on return to IDLE.
REQ-020 md counter (4 bits) SHALL load MD_LAT on md_start_ex, else decrement toward 0; md_busy = (counter!=0), registered, so it rises the cycle after md_start_ex.
REQ-021 md_start_ex while md_busy SHALL reload the counter to MD_LAT (restart).
REQ-022 md_use_id & md_busy SHALL assert stall and flush_ex combinationally.
REQ-023 Simultaneous lu and md stall SHALL OR into stall/flush_ex; the FSM transition is as if lu were alone.
REQ-024 stall_cnt SHALL increment by 1 on every clock with stall=1 and saturate at 16'hFFFF.
REQ-025 flush_ex SHALL equal stall in every cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL set FSM=IDLE, lcnt=0, md counter=0 (md_busy=0), stall_cnt=0, overriding all other inputs, including mid-LOAD_STALL or mid-mul/div.
REQ-027 While rst=1, stall and flush_ex SHALL be 0 and fwd_a/fwd_b SHALL be 00.

Verification
REQ-028 rs_id=5, rd_ex=5 wen_ex=1, rd_mem=5 wen_mem=1 -> fwd_a=10; then wen_ex=0 -> fwd_a=01; rd_ex=rd_mem=0 with rd_wb=5 wen_wb=1 -> fwd_a=11 (unless rs_id=0, then 00).
REQ-029 LOAD_LAT=1, load_ex=1 rd_ex=8 wen_ex=1, rt_id=8 use_rt_id=1 -> stall=flush_ex=1 for exactly 1 cycle, stall_cnt 0->1; same with use_rt_id=0 -> no stall.
REQ-030 LOAD_LAT=3, same load-use -> stall high exactly 3 consecutive cycles even if load_ex drops after cycle 1; stall_cnt=3.
REQ-031 MD_LAT=4, md_start_ex pulse at cycle 0 -> md_busy=1 cycles 1-4; md_use_id=1 at cycle 2 -> stall=1; repeat start at cycle 2 -> md_busy through cycle 6.
REQ-032 rst asserted in 2nd cycle of a LOAD_LAT=3 stall -> next cycle stall=0, md_busy=0, stall_cnt=0; stall_cnt forced to 16'hFFFF plus a further stall -> holds 16'hFFFF.
